alu_exec_ctrl: RTL and testbench

Multi-cycle execute sequencer for the integer ALU. It accepts one instruction at a time over a valid/ready handshake and reads rs1/rs2 from the synchronous-read register file. It presents the operands and the raw instruction word to the combinational ALU, then writes the result back to rd. LUI and AUIPC results are formed locally because the ALU does not implement them. Illegal encodings are flagged and never written back.

---
 rtl/alu_exec_ctrl_pkg.sv | 17 +
 rtl/alu_exec_ctrl_decode.sv | 44 ++++
 rtl/alu_exec_ctrl.sv | 120 ++++++++++++
 tb/tb_alu_exec_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_ctrl_pkg.sv
// Shared constants and types for the ALU execute sequencer.
package alu_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_MUL   = 7'b0000001;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  typedef enum logic [1:0] {K_ALU, K_LUI, K_AUIPC, K_ILLEGAL} kind_t;

endpackage

// File: rtl/alu_exec_ctrl_decode.sv
// Combinational classifier: instruction fields -> execution kind, with
// every encoding outside the supported set mapped to K_ILLEGAL.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output kind_t      kind
);

  logic f7_base;
  logic f7_alt;
  logic f7_mul;

  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);
  assign f7_mul  = (funct7 == F7_MUL);

  // Legality and kind lookup; default is illegal.
  always_comb begin
    kind = K_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct3)
          3'b000:  if (f7_base || f7_alt || f7_mul) kind = K_ALU;
          3'b101:  if (f7_base || f7_alt)           kind = K_ALU;
          default: if (f7_base)                     kind = K_ALU;
        endcase
      end
      OP_ITYPE: begin
        case (funct3)
          3'b001:  if (f7_base)           kind = K_ALU;
          3'b101:  if (f7_base || f7_alt) kind = K_ALU;
          default:                        kind = K_ALU;
        endcase
      end
      OP_LUI:   kind = K_LUI;
      OP_AUIPC: kind = K_AUIPC;
      default:  kind = K_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute sequencer: IDLE -> READ -> EXEC -> WB, one
// instruction per four cycles, writing the result back to the register file.
module alu_exec_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  input  logic [XLEN-1:0]    pc,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  output logic [31:0]        alu_code,
  output logic [XLEN-1:0]    alu_rs1,
  output logic [XLEN-1:0]    alu_rs2,
  input  logic [XLEN-1:0]    alu_rd,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               done,
  output logic               illegal
);

  state_t          state;
  state_t          state_nxt;
  kind_t           kind_dec;
  kind_t           kind_q;
  logic [XLEN-1:0] pc_q;
  logic            accept;
  logic [31:0]     imm_u;

  alu_op_decode u_decode (
    .opcode (instr[6:0]),
    .funct3 (instr[14:12]),
    .funct7 (instr[31:25]),
    .kind   (kind_dec)
  );

  // Register addresses come straight from the latched word, so they are
  // stable from READ through WB and read as zero after reset.
  assign rf_raddr1 = RADDR_W'(alu_code[19:15]);
  assign rf_raddr2 = RADDR_W'(alu_code[24:20]);
  assign rf_waddr  = RADDR_W'(alu_code[11:7]);
  assign imm_u     = {alu_code[31:12], 12'b0};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    accept      = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    rf_we       = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept    = 1'b1;
          state_nxt = READ;
        end
      end
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      WB: begin
        done      = 1'b1;
        illegal   = (kind_q == K_ILLEGAL);
        rf_we     = (kind_q != K_ILLEGAL) && (alu_code[11:7] != 5'd0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction latch at the handshake and operand capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_code <= '0;
      pc_q     <= '0;
      kind_q   <= K_ALU;
      alu_rs1  <= '0;
      alu_rs2  <= '0;
    end else begin
      if (accept) begin
        alu_code <= instr;
        pc_q     <= pc;
        kind_q   <= kind_dec;
      end
      if (state == EXEC) begin
        alu_rs1 <= rf_rdata1;
        alu_rs2 <= rf_rdata2;
      end
    end
  end

  // Write-back data: ALU result, or the locally formed upper-immediate forms.
  always_comb begin
    rf_wdata = alu_rd;
    case (kind_q)
      K_LUI:   rf_wdata = XLEN'(imm_u);
      K_AUIPC: rf_wdata = pc_q + XLEN'(imm_u);
      default: rf_wdata = alu_rd;
    endcase
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: environment register file and ALU,
// an instruction-level reference model, and a per-cycle compare process.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc_in = '0;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] alu_code, alu_rs1, alu_rs2, alu_rd;
  logic        rf_we, done, illegal;
  logic [31:0] rf_wdata;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Literal expectations attached to the instruction currently offered.
  bit          lit_en = 1'b0;
  bit          lit_we = 1'b0;
  bit          lit_ill = 1'b0;
  logic [4:0]  lit_wa = '0;
  logic [31:0] lit_wd = '0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.XLEN(32), .RADDR_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc          (pc_in),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .alu_code    (alu_code),
    .alu_rs1     (alu_rs1),
    .alu_rs2     (alu_rs2),
    .alu_rd      (alu_rd),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .done        (done),
    .illegal     (illegal)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 0) return 32'd0;
    if (i == 1) return 32'd5;
    if (i == 2) return 32'd7;
    return i * 32'h9E3779B9;
  endfunction

  // RV32 integer semantics for the word presented to the ALU.
  function automatic logic [31:0] alu_fn(input logic [31:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] op2;
    logic [4:0]  sh;
    logic [31:0] r;
    op2 = (c[6:0] == 7'h13) ? {{20{c[31]}}, c[31:20]} : b;
    sh  = op2[4:0];
    case (c[14:12])
      3'd0: begin
        if (c[6:0] == 7'h33 && c[31:25] == 7'h20)      r = a - b;
        else if (c[6:0] == 7'h33 && c[31:25] == 7'h01) r = a * b;
        else                                           r = a + op2;
      end
      3'd1:    r = a << sh;
      3'd2:    r = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
      3'd3:    r = (a < op2) ? 32'd1 : 32'd0;
      3'd4:    r = a ^ op2;
      3'd5:    r = c[30] ? $unsigned($signed(a) >>> sh) : (a >> sh);
      3'd6:    r = a | op2;
      default: r = a & op2;
    endcase
    return r;
  endfunction

  function automatic bit is_legal(input logic [31:0] w);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (op == 7'h33)
      return (f7 == 7'h00) || (f3 == 3'd0 && (f7 == 7'h20 || f7 == 7'h01)) || (f3 == 3'd5 && f7 == 7'h20);
    if (op == 7'h13)
      return (f3 != 3'd1 && f3 != 3'd5) || (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
    return (op == 7'h37) || (op == 7'h17);
  endfunction

  function automatic logic [31:0] ref_val(input logic [31:0] w, input logic [31:0] p,
                                          input logic [31:0] a, input logic [31:0] b);
    if (w[6:0] == 7'h37) return {w[31:12], 12'h000};
    if (w[6:0] == 7'h17) return p + {w[31:12], 12'h000};
    return alu_fn(w, a, b);
  endfunction

  // Environment: synchronous-read register file written by the DUT.
  logic [31:0] env_rf [32];
  bit          env_seeded = 1'b0;
  always @(posedge clk) begin
    if (!env_seeded) begin
      for (int i = 0; i < 32; i++) env_rf[i] <= init_val(i);
      env_seeded <= 1'b1;
    end else if (rf_we) begin
      env_rf[rf_waddr] <= rf_wdata;
    end
    rf_rdata1 <= env_rf[rf_raddr1];
    rf_rdata2 <= env_rf[rf_raddr2];
  end

  // Environment: combinational ALU.
  assign alu_rd = alu_fn(alu_code, alu_rs1, alu_rs2);

  // Reference model: accept when idle, retire three edges later.
  logic [31:0] arch [32];
  bit          m_seeded = 1'b0;
  bit          m_pend = 1'b0;
  int unsigned m_age = 0;
  logic [31:0] m_instr, m_a, m_b, m_wd;
  bit          m_we, m_ill;
  bit          m_len, m_lwe, m_lill;
  logic [4:0]  m_lwa;
  logic [31:0] m_lwd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      if (!m_seeded) begin
        for (int i = 0; i < 32; i++) arch[i] <= init_val(i);
        m_seeded <= 1'b1;
      end
    end else if (m_pend) begin
      if (m_age == 2) begin
        if (m_we) arch[m_instr[11:7]] <= m_wd;
        m_pend <= 1'b0;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (instr_valid) begin
      m_pend  <= 1'b1;
      m_age   <= 0;
      m_instr <= instr;
      m_a     <= arch[instr[19:15]];
      m_b     <= arch[instr[24:20]];
      m_ill   <= !is_legal(instr);
      m_we    <= is_legal(instr) && (instr[11:7] != 5'd0);
      m_wd    <= ref_val(instr, pc_in, arch[instr[19:15]], arch[instr[24:20]]);
      m_len   <= lit_en;
      m_lwe   <= lit_we;
      m_lill  <= lit_ill;
      m_lwa   <= lit_wa;
      m_lwd   <= lit_wd;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_we", 32'(rf_we), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_alu_code", alu_code, 32'd0);
      chk("rst_alu_rs1", alu_rs1, 32'd0);
      chk("rst_alu_rs2", alu_rs2, 32'd0);
      chk("rst_raddr1", 32'(rf_raddr1), 32'd0);
      chk("rst_raddr2", 32'(rf_raddr2), 32'd0);
      chk("rst_waddr", 32'(rf_waddr), 32'd0);
    end else if (m_seeded) begin
      chk("ready", 32'(instr_ready), 32'(!m_pend));
      if (m_pend) begin
        chk("raddr1", 32'(rf_raddr1), 32'(m_instr[19:15]));
        chk("raddr2", 32'(rf_raddr2), 32'(m_instr[24:20]));
      end
      if (m_pend && m_age == 2) begin
        chk("wb_done", 32'(done), 32'd1);
        chk("wb_illegal", 32'(illegal), 32'(m_ill));
        chk("wb_we", 32'(rf_we), 32'(m_we));
        chk("wb_alu_code", alu_code, m_instr);
        chk("wb_alu_rs1", alu_rs1, m_a);
        chk("wb_alu_rs2", alu_rs2, m_b);
        if (m_we) begin
          chk("wb_waddr", 32'(rf_waddr), 32'(m_instr[11:7]));
          chk("wb_wdata", rf_wdata, m_wd);
        end
        if (m_len) begin
          chk("lit_we", 32'(rf_we), 32'(m_lwe));
          chk("lit_illegal", 32'(illegal), 32'(m_lill));
          if (m_lwe) begin
            chk("lit_waddr", 32'(rf_waddr), 32'(m_lwa));
            chk("lit_wdata", rf_wdata, m_lwd);
          end
        end
      end else begin
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_we", 32'(rf_we), 32'd0);
        chk("idle_illegal", 32'(illegal), 32'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] w, input logic [31:0] p, input bit hold,
                       input bit len, input bit lwe, input logic [4:0] lwa,
                       input logic [31:0] lwd, input bit lill);
    int unsigned n;
    instr       = w;
    pc_in       = p;
    lit_en      = len;
    lit_we      = lwe;
    lit_wa      = lwa;
    lit_wd      = lwd;
    lit_ill     = lill;
    instr_valid = 1'b1;
    n = 0;
    @(negedge clk); #1;
    while (!instr_ready) begin
      n++;
      if (n > 20) begin
        $display("FAIL accept_timeout: got ready=0 expected ready=1 within 20 cycles");
        $fatal(1, "accept timeout");
      end
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  function automatic logic [6:0] pick_f7();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return 7'h00;
      1:       return 7'h20;
      2:       return 7'h01;
      default: return r[6:0];
    endcase
  endfunction

  initial begin
    logic [31:0] w;
    logic [31:0] p;
    bit          hold;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // ADD x3,x1,x2 with x1=5, x2=7
    issue(32'h002081B3, 32'h0, 1'b0, 1'b1, 1'b1, 5'd3, 32'd12, 1'b0);
    // LUI x5,0xABCDE
    issue(32'hABCDE2B7, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5, 32'hABCDE000, 1'b0);
    // AUIPC x6,1 at pc 0x100
    issue(32'h00001317, 32'h100, 1'b0, 1'b1, 1'b1, 5'd6, 32'h00001100, 1'b0);
    // ADDI x0,x1,1: retires without a write
    issue(32'h00108013, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    // Illegal system word, then R-type funct7=0000001 funct3=101
    issue(32'h00000073, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    issue(32'h0220D1B3, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    // Back-to-back: ADDI x1,x0,4 then SLLI x2,x1,2 with valid held
    issue(32'h00400093, 32'h0, 1'b1, 1'b1, 1'b1, 5'd1, 32'd4, 1'b0);
    issue(32'h00209113, 32'h0, 1'b0, 1'b1, 1'b1, 5'd2, 32'd16, 1'b0);

    // Reset pulsed during EXEC aborts the ADD; a handshake offered during
    // reset is ignored, and the next ADD (x1=4, x2=16) completes normally.
    issue(32'h002081B3, 32'h0, 1'b0, 1'b1, 1'b1, 5'd3, 32'd20, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    instr_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    issue(32'h002081B3, 32'h0, 1'b0, 1'b1, 1'b1, 5'd3, 32'd20, 1'b0);

    // Randomized mix of legal and illegal encodings.
    for (int unsigned i = 0; i < 250; i++) begin
      w = $urandom;
      p = $urandom;
      case ($urandom_range(0, 5))
        0: begin w[6:0] = 7'h33; w[31:25] = pick_f7(); end
        1, 2: begin
          w[6:0] = 7'h13;
          if (w[14:12] == 3'd1 || w[14:12] == 3'd5) w[31:25] = pick_f7();
        end
        3: w[6:0] = 7'h37;
        4: w[6:0] = 7'h17;
        default: ;
      endcase
      hold = ($urandom_range(0, 1) == 1) && (i != 249);
      issue(w, p, hold, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    instr_valid = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
